// File: rtl/vid_pkg.sv
// vid_seq shared types: SEW codes, FSM states, elements-per-beat helper.
package vid_pkg;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Elements carried by one beat at the given element width.
  function automatic int unsigned epb(input logic [2:0] sew, input int unsigned width);
    return width >> sew;
  endfunction

endpackage

// File: rtl/vid_if.sv
// Instruction, v0-mask and beat signals of the vid sequencer.
interface vid_if #(
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int VL_WIDTH          = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic [VL_WIDTH-1:0]          in_vl;
  logic [2:0]                   in_sew;
  logic                         in_vm;
  logic [REQ_ADDR_WIDTH-1:0]    in_addr;

  logic                         mask_valid;
  logic [REQ_BYTE_EN_WIDTH-1:0] mask_data;
  logic                         mask_ready;

  logic                         out_valid;
  logic [REQ_ADDR_WIDTH-1:0]    out_addr;
  logic [2:0]                   out_sew;
  logic [VL_WIDTH-1:0]          out_start_idx;
  logic [REQ_BYTE_EN_WIDTH-1:0] out_mask;
  logic                         out_last;
  logic                         done;
  logic                         err;

  modport master (
    output in_valid, in_vl, in_sew, in_vm, in_addr, mask_valid, mask_data,
    input  in_ready, mask_ready, out_valid, out_addr, out_sew, out_start_idx,
           out_mask, out_last, done, err
  );

  modport slave (
    input  in_valid, in_vl, in_sew, in_vm, in_addr, mask_valid, mask_data,
    output in_ready, mask_ready, out_valid, out_addr, out_sew, out_start_idx,
           out_mask, out_last, done, err
  );

endinterface

// File: rtl/vid_tail_mask.sv
// Per-element enable for one beat: lane in range, element below vl, v0 bit set.
module vid_tail_mask
  import vid_pkg::*;
#(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int VL_WIDTH          = 16
) (
  input  logic [VL_WIDTH:0]          elem_cnt,
  input  logic [VL_WIDTH-1:0]        vl,
  input  logic [2:0]                 sew,
  input  logic                       vm,
  input  logic [REQ_BYTE_EN_WIDTH-1:0] mask_data,
  output logic [REQ_BYTE_EN_WIDTH-1:0] mask
);

  localparam int IW = VL_WIDTH + 2;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
      mask[i] = (i < epb(sew, REQ_BYTE_EN_WIDTH))
             && (({1'b0, elem_cnt} + IW'(i)) < {2'b00, vl})
             && (vm || mask_data[i]);
    end
  end

endmodule

// File: rtl/vid_seq.sv
// vid instruction sequencer: splits one instruction into 64-bit index beats.
module vid_seq
  import vid_pkg::*;
#(
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int VL_WIDTH          = 16,
  parameter int ADDR_INC          = 1
) (
  input logic   clk,
  input logic   rst,
  vid_if.slave  bus
);

  localparam int IW = VL_WIDTH + 2;

  state_t                       state;
  state_t                       state_nxt;
  logic [VL_WIDTH-1:0]          vl_q;
  logic [2:0]                   sew_q;
  logic                         vm_q;
  logic [REQ_ADDR_WIDTH-1:0]    addr_q;
  logic [VL_WIDTH:0]            elem_cnt;
  logic [REQ_BYTE_EN_WIDTH-1:0] beat_mask;
  logic                         accept;
  logic                         illegal;
  logic                         fire;
  logic                         last;

  assign bus.in_ready   = (state == IDLE) && !rst;
  assign accept         = bus.in_valid && bus.in_ready;
  assign illegal        = bus.in_sew > SEW_64;
  assign fire           = (state == RUN) && (vm_q || bus.mask_valid) && !rst;
  assign bus.mask_ready = (state == RUN) && !vm_q && bus.mask_valid && !rst;
  assign last = ({1'b0, elem_cnt} + IW'(epb(sew_q, REQ_BYTE_EN_WIDTH))) >= {2'b00, vl_q};

  vid_tail_mask #(
    .REQ_BYTE_EN_WIDTH (REQ_BYTE_EN_WIDTH),
    .VL_WIDTH          (VL_WIDTH)
  ) u_tail_mask (
    .elem_cnt  (elem_cnt),
    .vl        (vl_q),
    .sew       (sew_q),
    .vm        (vm_q),
    .mask_data (bus.mask_data),
    .mask      (beat_mask)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: zero-length and illegal-sew instructions never leave IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (bus.in_vl != '0) && !illegal) state_nxt = RUN;
      RUN:  if (fire && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch, counters and registered beat outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_q              <= '0;
      sew_q             <= '0;
      vm_q              <= 1'b0;
      addr_q            <= '0;
      elem_cnt          <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_addr      <= '0;
      bus.out_sew       <= '0;
      bus.out_start_idx <= '0;
      bus.out_mask      <= '0;
      bus.out_last      <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_mask  <= '0;
      bus.out_last  <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      if (accept) begin
        vl_q     <= bus.in_vl;
        sew_q    <= bus.in_sew;
        vm_q     <= bus.in_vm;
        addr_q   <= bus.in_addr;
        elem_cnt <= '0;
        if ((bus.in_vl == '0) || illegal) begin
          bus.done <= 1'b1;
          bus.err  <= illegal;
        end
      end else if (fire) begin
        bus.out_valid     <= 1'b1;
        bus.out_addr      <= addr_q;
        bus.out_start_idx <= elem_cnt[VL_WIDTH-1:0];
        bus.out_sew       <= sew_q;
        bus.out_mask      <= beat_mask;
        bus.out_last      <= last;
        bus.done          <= last;
        elem_cnt          <= elem_cnt + (VL_WIDTH+1)'(epb(sew_q, REQ_BYTE_EN_WIDTH));
        addr_q            <= addr_q + REQ_ADDR_WIDTH'(ADDR_INC);
      end
    end
  end

endmodule
